// File: rtl/xnorpop_pkg.sv
// Shared types and width helpers for the XNOR-popcount accumulator family.
package xnorpop_pkg;

    typedef enum logic [1:0] {
        ACC,
        DRAIN,
        HOLD
    } state_e;

    // Bits needed to hold a popcount of `width` bits.
    function automatic int pop_w(int width);
        return $clog2(width + 1);
    endfunction

    // Bits needed for the accumulated sum plus one sign bit.
    function automatic int sum_w(int width, int max_beats);
        return $clog2(width * max_beats + 1) + 1;
    endfunction

endpackage

// File: rtl/xnor_popcount_tree.sv
// Combinational XNOR followed by a balanced binary adder tree that counts
// matching bit positions of x and y.
module xnor_popcount_tree
    import xnorpop_pkg::*;
#(
    parameter int WIDTH = 128
) (
    input  logic [WIDTH-1:0]           x,
    input  logic [WIDTH-1:0]           y,
    output logic [$clog2(WIDTH+1)-1:0] pop
);

    localparam int POP_W = pop_w(WIDTH);
    localparam int NP    = 1 << $clog2(WIDTH);

    // Leaves beyond WIDTH are zero so the tree can be a full power of two.
    logic [NP-1:0]    match;
    logic [POP_W-1:0] node [1:2*NP-1];

    assign match = NP'(~(x ^ y));

    // Heap-ordered tree: leaves at NP..2NP-1, node k sums children 2k and 2k+1.
    always_comb begin
        for (int i = 0; i < NP; i++) begin
            node[NP+i] = POP_W'(match[i]);
        end
        for (int k = NP - 1; k >= 1; k--) begin
            node[k] = node[2*k] + node[2*k+1];
        end
    end

    assign pop = node[1];

endmodule

// File: rtl/xnor_popcount_accum.sv
// Streaming XNOR-popcount dot-product engine. Beats are popcounted in a
// register stage, accumulated until in_last (or MAX_BEATS), then the total
// is held on a valid/ready output.
// Build option XNORPOP_SIGNED_EN: out_sum becomes the signed +/-1 dot product
// 2*acc - WIDTH*beats instead of the raw matching-bit count.
module xnor_popcount_accum
    import xnorpop_pkg::*;
#(
    parameter int WIDTH     = 128,
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = $clog2(MAX_BEATS + 1),
    parameter int SUM_W     = sum_w(WIDTH, MAX_BEATS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_beats,
    output logic             out_trunc
);

    localparam int POP_W = pop_w(WIDTH);
    localparam int ACC_W = SUM_W - 1;
    localparam logic [CNT_W:0] LAST_CNT = (CNT_W + 1)'(MAX_BEATS);

    state_e           state_q, state_d;
    logic [POP_W-1:0] pop, s1_pop_q;
    logic             s1_valid_q, s1_end_q;
    logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_W:0]   cnt_inc;
    logic             trunc_q, trunc_d;
    logic [SUM_W-1:0] out_sum_q, out_sum_d, result;
    logic             beat_fire, end_beat;

    xnor_popcount_tree #(
        .WIDTH (WIDTH)
    ) u_tree (
        .x   (in_x),
        .y   (in_y),
        .pop (pop)
    );

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == HOLD);
    assign beat_fire = in_valid & in_ready;
    assign cnt_inc   = {1'b0, beat_cnt_q} + 1'b1;
    assign end_beat  = in_last | (cnt_inc == LAST_CNT);
    assign acc_sum   = acc_q + ACC_W'(s1_pop_q);

`ifdef XNORPOP_SIGNED_EN
    // Modular SUM_W arithmetic yields the correct two's-complement value.
    assign result = {acc_sum, 1'b0} - (SUM_W'(WIDTH) * SUM_W'(beat_cnt_q));
`else
    assign result = {1'b0, acc_sum};
`endif

    // Stage 1: register the popcount of each accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_end_q   <= 1'b0;
            s1_pop_q   <= '0;
        end else begin
            s1_valid_q <= beat_fire;
            if (beat_fire) begin
                s1_pop_q <= pop;
                s1_end_q <= end_beat;
            end
        end
    end

    // FSM, accumulator, counter and held result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACC;
            acc_q      <= '0;
            beat_cnt_q <= '0;
            trunc_q    <= 1'b0;
            out_sum_q  <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            beat_cnt_q <= beat_cnt_d;
            trunc_q    <= trunc_d;
            out_sum_q  <= out_sum_d;
        end
    end

    // Next-state: accumulate beats, fold in the last stage-1 value, hold until taken.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        trunc_d    = trunc_q;
        out_sum_d  = out_sum_q;
        acc_d      = s1_valid_q ? acc_sum : acc_q;
        case (state_q)
            ACC: begin
                if (beat_fire) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (end_beat) begin
                        state_d = DRAIN;
                        if (!in_last) begin
                            trunc_d = 1'b1;
                        end
                    end
                end
            end
            DRAIN: begin
                if (s1_end_q) begin
                    state_d   = HOLD;
                    out_sum_d = result;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d    = ACC;
                    acc_d      = '0;
                    beat_cnt_d = '0;
                    trunc_d    = 1'b0;
                    out_sum_d  = '0;
                end
            end
            default: state_d = ACC;
        endcase
    end

    assign out_sum   = out_sum_q;
    assign out_beats = beat_cnt_q;
    assign out_trunc = trunc_q;

endmodule
